// File: rtl/rv_bus_defs.sv
// Shared definitions for the IF/MEM memory bus arbiter.
// Build option BUS_TIMEOUT_EN enables the bus watchdog.
package rv_bus_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } bus_state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Watchdog wait counter for the memory bus arbiter.
// Used only when BUS_TIMEOUT_EN is defined.
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Asserted on the wait cycle whose increment reaches the limit
    assign o_tc = i_en && (r_cnt == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between fetch and data, data first.
// Define BUS_TIMEOUT_EN to add a watchdog on missing bus_ack.
module mem_bus_arbiter
    import rv_bus_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    bus_state_e  r_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_if_rdata;
    logic        r_if_ready;
    logic [31:0] r_dm_rdata;
    logic        r_dm_ready;
    logic        r_bus_err;

    logic        w_busy;
    logic        w_tc;
    logic        w_done;
    logic        w_dm_elig;
    logic        w_if_elig;
    logic [31:0] w_rdata;

    assign w_busy    = (r_state != ST_IDLE);
    // A request held through its own ready cycle is already served
    assign w_dm_elig = dm_req && !r_dm_ready;
    assign w_if_elig = if_req && !r_if_ready;

`ifdef BUS_TIMEOUT_EN
    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset_n(reset_n),
        .i_clr  (!w_busy),
        .i_en   (w_busy && !bus_ack),
        .o_tc   (w_tc)
    );
`else
    // Unbounded wait: the limit is never reachable in range
    assign w_tc = (TIMEOUT_CYCLES == 0) && w_busy && !bus_ack;
`endif

    assign w_done  = bus_ack || w_tc;
    assign w_rdata = bus_ack ? bus_rdata : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_be    <= 4'h0;
            r_if_rdata  <= 32'h0;
            r_if_ready  <= 1'b0;
            r_dm_rdata  <= 32'h0;
            r_dm_ready  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_bus_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_dm_elig) begin
                        r_state     <= ST_DATA;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= dm_we;
                        r_bus_addr  <= dm_addr;
                        r_bus_wdata <= dm_wdata;
                        r_bus_be    <= dm_be;
                    end else if (w_if_elig) begin
                        r_state    <= ST_FETCH;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= if_addr;
                        r_bus_be   <= BE_WORD;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_bus_req  <= 1'b0;
                        r_dm_rdata <= w_rdata;
                        r_dm_ready <= 1'b1;
                        r_bus_err  <= !bus_ack;
                    end
                end
                ST_FETCH: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_bus_req  <= 1'b0;
                        r_if_rdata <= w_rdata;
                        r_if_ready <= 1'b1;
                        r_bus_err  <= !bus_ack;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ready  = r_dm_ready;
`ifdef BUS_TIMEOUT_EN
    assign bus_err   = r_bus_err;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter.
// Watchdog steps run only when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] dm_q[$];
    logic [31:0] if_q[$];

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_dm(input string tag);
        logic [31:0] e;
        if (dm_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = dm_q.pop_front();
            chk(tag, dm_rdata, e);
        end
    endtask

    task automatic pop_if(input string tag);
        logic [31:0] e;
        if (if_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = if_q.pop_front();
            chk(tag, if_rdata, e);
        end
    endtask

    task automatic drive_dm(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        dm_req = 1'b1; dm_we = we; dm_addr = a;
        dm_wdata = wd; dm_be = be;
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0;
        dm_wdata = 32'h0; dm_be = 4'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();

        // Reset values
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
        tick();
        bus_ack = 1'b0;
        tick();
        chk("idle_ack_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

        // Zero-wait load
        drive_dm(1'b0, 32'h100, 32'h0, 4'b0011);
        dm_q.push_back(32'hDEADBEEF);
        tick();
        chk("zw_bus_req", {31'd0, bus_req}, 32'd1);
        chk("zw_bus_addr", bus_addr, 32'h100);
        chk("zw_bus_be", {28'd0, bus_be}, 32'h3);
        chk("zw_early_ready", {31'd0, dm_ready}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0;
        chk("zw_dm_ready", {31'd0, dm_ready}, 32'd1);
        pop_dm("zw_dm_rdata");
        chk("zw_req_drop", {31'd0, bus_req}, 32'd0);
        dm_req = 1'b0;
        tick();
        chk("zw_pulse_end", {31'd0, dm_ready}, 32'd0);

        // Simultaneous requests: store first, fetch in dm_ready cycle
        if_req = 1'b1; if_addr = 32'h40;
        drive_dm(1'b1, 32'h80, 32'h12345678, 4'hF);
        dm_q.push_back(32'hAAAA0001);
        tick();
        chk("sim_st_we", {31'd0, bus_we}, 32'd1);
        chk("sim_st_wdata", bus_wdata, 32'h12345678);
        chk("sim_st_addr", bus_addr, 32'h80);
        tick(); tick();
        chk("sim_wait_req", {31'd0, bus_req}, 32'd1);
        chk("sim_wait_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hAAAA0001;
        tick();
        bus_ack = 1'b0;
        chk("sim_dm_ready", {31'd0, dm_ready}, 32'd1);
        pop_dm("sim_dm_rdata");
        chk("sim_gap_req", {31'd0, bus_req}, 32'd0);
        dm_req = 1'b0;
        if_q.push_back(32'h00000013);
        tick();
        chk("sim_f_req", {31'd0, bus_req}, 32'd1);
        chk("sim_f_we", {31'd0, bus_we}, 32'd0);
        chk("sim_f_be", {28'd0, bus_be}, 32'hF);
        chk("sim_f_addr", bus_addr, 32'h40);
        bus_ack = 1'b1; bus_rdata = 32'h00000013;
        tick();
        bus_ack = 1'b0;
        chk("sim_if_ready", {31'd0, if_ready}, 32'd1);
        pop_if("sim_if_rdata");

        // Held fetch request is not re-issued in its ready cycle
        tick();
        chk("held_no_req", {31'd0, bus_req}, 32'd0);
        chk("held_pulse_end", {31'd0, if_ready}, 32'd0);
        if_req = 1'b0;
        tick();

        // Field stability while in DATA
        drive_dm(1'b0, 32'h200, 32'h0, 4'hF);
        dm_q.push_back(32'h00005555);
        tick();
        chk("stab_addr0", bus_addr, 32'h200);
        dm_addr = 32'h300;
        tick();
        chk("stab_addr1", bus_addr, 32'h200);
        bus_ack = 1'b1; bus_rdata = 32'h00005555;
        tick();
        bus_ack = 1'b0;
        chk("stab_ready", {31'd0, dm_ready}, 32'd1);
        pop_dm("stab_rdata");
        dm_req = 1'b0;
        tick();

        // Reset mid-transaction
        drive_dm(1'b0, 32'h400, 32'h0, 4'hF);
        tick();
        chk("mrst_req_on", {31'd0, bus_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_req_off", {31'd0, bus_req}, 32'd0);
        dm_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mrst_no_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("mrst_rdata", dm_rdata, 32'd0);
        if_req = 1'b1; if_addr = 32'h44;
        if_q.push_back(32'hFEEDF00D);
        tick();
        chk("mrst_f_addr", bus_addr, 32'h44);
        bus_ack = 1'b1; bus_rdata = 32'hFEEDF00D;
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0;
        chk("mrst_if_ready", {31'd0, if_ready}, 32'd1);
        pop_if("mrst_if_rdata");
        chk("mrst_no_err", {31'd0, bus_err}, 32'd0);
        tick();

`ifdef BUS_TIMEOUT_EN
        // Ack on the terminal cycle completes normally
        drive_dm(1'b0, 32'h500, 32'h0, 4'hF);
        dm_q.push_back(32'hCAFE0004);
        tick(); tick(); tick(); tick();
        chk("wd_tc_req", {31'd0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE0004;
        tick();
        bus_ack = 1'b0;
        dm_req = 1'b0;
        chk("wd_tc_ready", {31'd0, dm_ready}, 32'd1);
        chk("wd_tc_err", {31'd0, bus_err}, 32'd0);
        pop_dm("wd_tc_rdata");
        tick();

        // No ack: watchdog fires after four wait cycles
        drive_dm(1'b0, 32'h600, 32'h0, 4'hF);
        dm_q.push_back(32'h0);
        tick(); tick(); tick(); tick();
        chk("wd_wait_ready", {31'd0, dm_ready}, 32'd0);
        tick();
        dm_req = 1'b0;
        chk("wd_ready", {31'd0, dm_ready}, 32'd1);
        chk("wd_err", {31'd0, bus_err}, 32'd1);
        chk("wd_req_off", {31'd0, bus_req}, 32'd0);
        pop_dm("wd_rdata");
        tick();
        chk("wd_err_end", {31'd0, bus_err}, 32'd0);
`else
        // Without the watchdog the wait is unbounded
        drive_dm(1'b0, 32'h600, 32'h0, 4'hF);
        dm_q.push_back(32'h00000777);
        for (int i = 0; i < 8; i++) tick();
        chk("nowd_still_req", {31'd0, bus_req}, 32'd1);
        chk("nowd_no_ready", {31'd0, dm_ready}, 32'd0);
        chk("nowd_no_err", {31'd0, bus_err}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h00000777;
        tick();
        bus_ack = 1'b0;
        dm_req = 1'b0;
        chk("nowd_ready", {31'd0, dm_ready}, 32'd1);
        pop_dm("nowd_rdata");
        tick();
`endif

        chk("sb_drained", dm_q.size() + if_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
